// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide sequencer: computes the result at accept, holds it
// pending for a fixed latency, then commits it to the architectural HI/LO.
module mdu_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use,
  input  logic        cancel,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

  state_e      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_pend_hi, w_pend_hi_nxt;
  logic [31:0] r_pend_lo, w_pend_lo_nxt;
  logic        r_pend_wr, w_pend_wr_nxt;
  logic [31:0] r_hi, w_hi_nxt;
  logic [31:0] r_lo, w_lo_nxt;

  md_op_e      w_op;
  logic        w_accept;
  logic        w_is_md;
  logic [63:0] w_prod_s, w_prod_u;
  logic        w_rs_neg, w_rt_neg;
  logic [31:0] w_rs_mag, w_rt_mag, w_div_s, w_div_u;
  logic [31:0] w_quo_mag, w_rem_mag, w_quo_s, w_rem_s, w_quo_u, w_rem_u;

  assign w_op     = md_op_e'(md_op);
  assign w_is_md  = (md_op >= 3'd1) && (md_op <= 3'd4);
  assign w_accept = (r_state == ST_IDLE) && !cancel && (md_op >= 3'd1) && (md_op <= 3'd6);

  // Lower 64 bits of the sign-extended product equal the signed 32x32 product.
  assign w_prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed divide on magnitudes avoids the 0x80000000 / -1 overflow corner.
  assign w_rs_neg  = rs_val[31];
  assign w_rt_neg  = rt_val[31];
  assign w_rs_mag  = w_rs_neg ? (~rs_val + 32'd1) : rs_val;
  assign w_rt_mag  = w_rt_neg ? (~rt_val + 32'd1) : rt_val;
  assign w_div_s   = (rt_val == 32'd0) ? 32'd1 : w_rt_mag;
  assign w_div_u   = (rt_val == 32'd0) ? 32'd1 : rt_val;
  assign w_quo_mag = w_rs_mag / w_div_s;
  assign w_rem_mag = w_rs_mag % w_div_s;
  assign w_quo_s   = (w_rs_neg ^ w_rt_neg) ? (~w_quo_mag + 32'd1) : w_quo_mag;
  assign w_rem_s   = w_rs_neg ? (~w_rem_mag + 32'd1) : w_rem_mag;
  assign w_quo_u   = rs_val / w_div_u;
  assign w_rem_u   = rs_val % w_div_u;

  always_comb begin
    // NOTE: every signal starts from its held value so no path leaves it unassigned (no latch).
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
    w_pend_wr_nxt = r_pend_wr;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (w_op)
            OP_MULT: begin
              {w_pend_hi_nxt, w_pend_lo_nxt} = w_prod_s;
              w_pend_wr_nxt = 1'b1;
              w_cnt_nxt     = MUL_N;
              w_state_nxt   = ST_BUSY;
            end
            OP_MULTU: begin
              {w_pend_hi_nxt, w_pend_lo_nxt} = w_prod_u;
              w_pend_wr_nxt = 1'b1;
              w_cnt_nxt     = MUL_N;
              w_state_nxt   = ST_BUSY;
            end
            OP_DIV: begin
              w_pend_hi_nxt = w_rem_s;
              w_pend_lo_nxt = w_quo_s;
              w_pend_wr_nxt = (rt_val != 32'd0);
              w_cnt_nxt     = DIV_N;
              w_state_nxt   = ST_BUSY;
            end
            OP_DIVU: begin
              w_pend_hi_nxt = w_rem_u;
              w_pend_lo_nxt = w_quo_u;
              w_pend_wr_nxt = (rt_val != 32'd0);
              w_cnt_nxt     = DIV_N;
              w_state_nxt   = ST_BUSY;
            end
            OP_MTHI: w_hi_nxt = rs_val;
            OP_MTLO: w_lo_nxt = rs_val;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        if (cancel || r_cnt <= 4'd1) begin
          // A flush wins over a same-edge commit.
          if (!cancel && r_pend_wr) begin
            w_hi_nxt = r_pend_hi;
            w_lo_nxt = r_pend_lo;
          end
          w_state_nxt   = ST_IDLE;
          w_cnt_nxt     = 4'd0;
          w_pend_hi_nxt = 32'd0;
          w_pend_lo_nxt = 32'd0;
          w_pend_wr_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
      r_pend_wr <= w_pend_wr_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
    end
  end

  assign busy  = (r_state == ST_BUSY);
  assign stall = md_use & (busy | ((r_state == ST_IDLE) & w_is_md & ~cancel));
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl against an arithmetic reference model.
module tb_mdu_ctrl;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        md_use, cancel;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mdu_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset_n(reset_n), .md_op(md_op), .rs_val(rs_val), .rt_val(rt_val),
    .md_use(md_use), .cancel(cancel), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model: architectural result and latency of one operation.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] mhi, inout logic [31:0] mlo, output int n);
    int sa, sb;
    longint la, lb, p, q, r;
    longint unsigned ua, ub, up;
    sa = a; sb = b; la = sa; lb = sb;
    ua = a; ub = b;
    n = 0;
    case (op)
      3'd1: begin p = la * lb; mhi = p[63:32]; mlo = p[31:0]; n = MUL_N; end
      3'd2: begin up = ua * ub; mhi = up[63:32]; mlo = up[31:0]; n = MUL_N; end
      3'd3: begin
        if (b != 0) begin q = la / lb; r = la % lb; mlo = q[31:0]; mhi = r[31:0]; end
        n = DIV_N;
      end
      3'd4: begin
        if (b != 0) begin up = ua / ub; mlo = up[31:0]; up = ua % ub; mhi = up[31:0]; end
        n = DIV_N;
      end
      3'd5: mhi = a;
      3'd6: mlo = a;
      default: ;
    endcase
  endtask

  // Called just after a falling edge; returns just after a falling edge with busy low.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic use_d);
    logic [31:0] nhi, nlo;
    int n, cyc;
    logic exp_stall;
    nhi = exp_hi; nlo = exp_lo;
    model(op, a, b, nhi, nlo, n);
    md_op = op; rs_val = a; rt_val = b; md_use = use_d; cancel = 1'b0;
    #1;
    exp_stall = use_d && (op >= 3'd1) && (op <= 3'd4);
    n_checks++;
    if (stall !== exp_stall) begin
      n_errors++;
      $display("FAIL %s accept stall: got %b want %b", name, stall, exp_stall);
    end
    @(negedge clk);
    md_op = 3'd0; rs_val = $urandom; rt_val = $urandom;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      #1;
      n_checks++;
      if (hi !== exp_hi || lo !== exp_lo || stall !== use_d) begin
        n_errors++;
        $display("FAIL %s busy cyc %0d: hi=%h lo=%h stall=%b want hi=%h lo=%h stall=%b",
                 name, cyc, hi, lo, stall, exp_hi, exp_lo, use_d);
      end
      cyc++;
      @(negedge clk);
    end
    exp_hi = nhi; exp_lo = nlo;
    n_checks++;
    if (cyc != n) begin
      n_errors++;
      $display("FAIL %s busy length: got %0d want %0d", name, cyc, n);
    end
    n_checks++;
    if (hi !== exp_hi || lo !== exp_lo || stall !== 1'b0) begin
      n_errors++;
      $display("FAIL %s result: hi=%h lo=%h stall=%b want hi=%h lo=%h stall=0",
               name, hi, lo, stall, exp_hi, exp_lo);
    end
    md_use = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; md_op = 3'd0; rs_val = 32'd0; rt_val = 32'd0; md_use = 1'b0; cancel = 1'b0;
    #12;
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || stall !== 1'b0) begin
      n_errors++;
      $display("FAIL reset: hi=%h lo=%h busy=%b stall=%b want all 0", hi, lo, busy, stall);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_move();
    run_op("mthi", 3'd5, 32'h1234_5678, 32'd0, 1'b0);
    run_op("mtlo", 3'd6, 32'h9ABC_DEF0, 32'd0, 1'b0);
  endtask

  task automatic test_mult();
    run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      n_errors++;
      $display("FAIL mult const: hi=%h lo=%h want ffffffff fffffffa", hi, lo);
    end
    n_checks++;
    run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
    n_checks++;
    if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin
      n_errors++;
      $display("FAIL multu const: hi=%h lo=%h want 00000002 fffffffa", hi, lo);
    end
  endtask

  task automatic test_div();
    run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    n_checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      n_errors++;
      $display("FAIL div const: hi=%h lo=%h want ffffffff fffffffd", hi, lo);
    end
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      n_errors++;
      $display("FAIL div_ovf const: hi=%h lo=%h want 00000000 80000000", hi, lo);
    end
    run_op("divu_zero", 3'd4, 32'd7, 32'd0, 1'b0);
    run_op("div_zero", 3'd3, 32'hFFFF_FFF0, 32'd0, 1'b1);
  endtask

  task automatic test_cancel();
    run_op("pre_mthi", 3'd5, 32'hCAFE_0001, 32'd0, 1'b0);
    md_op = 3'd1; rs_val = 32'd1000; rt_val = 32'd1000;
    @(negedge clk);
    md_op = 3'd0;
    @(negedge clk);
    md_op = 3'd5; rs_val = 32'hDEAD_BEEF;
    @(negedge clk);
    md_op = 3'd0; cancel = 1'b1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL cancel busy before: got %b want 1", busy);
    end
    @(negedge clk);
    cancel = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      n_errors++;
      $display("FAIL cancel after: busy=%b hi=%h lo=%h want 0 %h %h", busy, hi, lo, exp_hi, exp_lo);
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      n_errors++;
      $display("FAIL cancel late: busy=%b hi=%h lo=%h want 0 %h %h", busy, hi, lo, exp_hi, exp_lo);
    end
    md_op = 3'd3; rs_val = 32'd9; rt_val = 32'd2; cancel = 1'b1;
    @(negedge clk);
    md_op = 3'd0; cancel = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL cancel same-cycle accept: busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_mult", 3'd1, 32'd123_456, 32'hFFFF_0000, 1'b1);
    run_op("b2b_divu", 3'd4, 32'hFFFF_FFFF, 32'd10, 1'b1);
    run_op("b2b_mtlo", 3'd6, 32'h0BAD_F00D, 32'd0, 1'b1);
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(1, 6));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: begin a = 32'($urandom_range(0, 200)) - 32'd100; b = 32'($urandom_range(0, 20)) - 32'd10; end
        2: if (i % 3 == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      run_op("random", op, a, b, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    run_op("pre_hi", 3'd5, 32'h5555_AAAA, 32'd0, 1'b0);
    run_op("pre_lo", 3'd6, 32'h3333_CCCC, 32'd0, 1'b0);
    md_op = 3'd3; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    md_op = 3'd0;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_errors++;
      $display("FAIL async reset: busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    exp_hi = 32'd0; exp_lo = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op("post_reset_mult", 3'd1, 32'd4, 32'd5, 1'b0);
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd20) begin
      n_errors++;
      $display("FAIL post_reset const: hi=%h lo=%h want 0 20", hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_move();
    test_mult();
    test_div();
    test_cancel();
    @(negedge clk);
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
